// File: rtl/picoriscv_csr_master_pkg.sv
// Shared CSR bus types and the master's local constants.
// Bus structs mirror the csr_request__* / csr_response__* port fields one to one.
package picoriscv_csr_master_pkg;

  typedef struct packed {
    logic        valid;
    logic        read_not_write;
    logic [15:0] select;
    logic [15:0] address;
    logic [31:0] data;
  } t_csr_request;

  typedef struct packed {
    logic        acknowledge;
    logic        read_data_valid;
    logic        read_data_error;
    logic [31:0] read_data;
  } t_csr_response;

  localparam int TIMER_W = 16;

  typedef logic [1:0] t_master_state;
  localparam t_master_state ST_IDLE      = 2'd0;
  localparam t_master_state ST_REQUEST   = 2'd1;
  localparam t_master_state ST_READ_WAIT = 2'd2;
  localparam t_master_state ST_COMPLETE  = 2'd3;

  // Saturating increment so a stalled phase can never wrap back to zero.
  function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/picoriscv_csr_master.sv
// CSR bus initiator: one host command in flight, turned into a csr_request and
// completed by ack (plus read data for reads) or by a per-phase timeout.
module picoriscv_csr_master
  import picoriscv_csr_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic        host_req_read_not_write,
  input  logic [15:0] host_req_select,
  input  logic [15:0] host_req_address,
  input  logic [31:0] host_req_data,
  output logic        host_rsp_valid,
  output logic        host_rsp_error,
  output logic        host_rsp_timeout,
  output logic [31:0] host_rsp_data,
  output logic        csr_request__valid,
  output logic        csr_request__read_not_write,
  output logic [15:0] csr_request__select,
  output logic [15:0] csr_request__address,
  output logic [31:0] csr_request__data,
  input  logic        csr_response__acknowledge,
  input  logic        csr_response__read_data_valid,
  input  logic        csr_response__read_data_error,
  input  logic [31:0] csr_response__read_data
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  t_master_state      state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               cmd_rnw_q, cmd_rnw_d;
  logic [15:0]        cmd_select_q, cmd_select_d;
  logic [15:0]        cmd_address_q, cmd_address_d;
  logic [31:0]        cmd_data_q, cmd_data_d;
  logic               rsp_error_q, rsp_error_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  t_csr_response      rsp;
  t_csr_request       req;

  assign rsp = '{acknowledge:     csr_response__acknowledge,
                 read_data_valid: csr_response__read_data_valid,
                 read_data_error: csr_response__read_data_error,
                 read_data:       csr_response__read_data};

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cmd_rnw_d     = cmd_rnw_q;
    cmd_select_d  = cmd_select_q;
    cmd_address_d = cmd_address_q;
    cmd_data_d    = cmd_data_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_data_d    = rsp_data_q;
    if (clk__enable) begin
      case (state_q)
        ST_IDLE: begin
          if (host_req_valid) begin
            cmd_rnw_d     = host_req_read_not_write;
            cmd_select_d  = host_req_select;
            cmd_address_d = host_req_address;
            cmd_data_d    = host_req_data;
            timer_d       = '0;
            state_d       = ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          // Ack is tested before the timer so an ack on the last allowed cycle still wins.
          if (rsp.acknowledge) begin
            if (!cmd_rnw_q) begin
              rsp_data_d  = '0;
              rsp_error_d = 1'b0;
              state_d     = ST_COMPLETE;
            end else if (rsp.read_data_valid) begin
              rsp_data_d  = rsp.read_data;
              rsp_error_d = rsp.read_data_error;
              state_d     = ST_COMPLETE;
            end else begin
              timer_d = '0;
              state_d = ST_READ_WAIT;
            end
          end else if (timer_q == TIMER_LAST) begin
            rsp_data_d    = '0;
            rsp_error_d   = 1'b0;
            rsp_timeout_d = 1'b1;
            state_d       = ST_COMPLETE;
          end else begin
            timer_d = timer_inc(timer_q);
          end
        end
        ST_READ_WAIT: begin
          if (rsp.read_data_valid) begin
            rsp_data_d  = rsp.read_data;
            rsp_error_d = rsp.read_data_error;
            state_d     = ST_COMPLETE;
          end else if (timer_q == TIMER_LAST) begin
            rsp_data_d    = '0;
            rsp_error_d   = 1'b0;
            rsp_timeout_d = 1'b1;
            state_d       = ST_COMPLETE;
          end else begin
            timer_d = timer_inc(timer_q);
          end
        end
        ST_COMPLETE: begin
          rsp_data_d    = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reset overrides the clock enable so an abandoned transaction clears on the next edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      cmd_rnw_q     <= 1'b0;
      cmd_select_q  <= '0;
      cmd_address_q <= '0;
      cmd_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cmd_rnw_q     <= cmd_rnw_d;
      cmd_select_q  <= cmd_select_d;
      cmd_address_q <= cmd_address_d;
      cmd_data_q    <= cmd_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  always_comb begin
    req = '0;
    if (state_q == ST_REQUEST) begin
      req.valid          = 1'b1;
      req.read_not_write = cmd_rnw_q;
      req.select         = cmd_select_q;
      req.address        = cmd_address_q;
      req.data           = cmd_data_q;
    end
  end

  assign csr_request__valid          = req.valid;
  assign csr_request__read_not_write = req.read_not_write;
  assign csr_request__select         = req.select;
  assign csr_request__address        = req.address;
  assign csr_request__data           = req.data;

  assign host_req_ready   = (state_q == ST_IDLE);
  assign host_rsp_valid   = (state_q == ST_COMPLETE);
  assign host_rsp_error   = host_rsp_valid & rsp_error_q;
  assign host_rsp_timeout = host_rsp_valid & rsp_timeout_q;
  assign host_rsp_data    = host_rsp_valid ? rsp_data_q : 32'h0;

endmodule

// File: tb/tb_picoriscv_csr_master.sv
// Directed bench for picoriscv_csr_master: transaction-level model of the expected
// completion, a per-cycle checker against it, and literal pins on key results.
module tb_picoriscv_csr_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        clk__enable = 1'b1;
  logic        reset_n = 1'b0;
  logic        host_req_valid = 1'b0;
  logic        host_req_ready;
  logic        host_req_read_not_write = 1'b0;
  logic [15:0] host_req_select = '0;
  logic [15:0] host_req_address = '0;
  logic [31:0] host_req_data = '0;
  logic        host_rsp_valid;
  logic        host_rsp_error;
  logic        host_rsp_timeout;
  logic [31:0] host_rsp_data;
  logic        csr_request__valid;
  logic        csr_request__read_not_write;
  logic [15:0] csr_request__select;
  logic [15:0] csr_request__address;
  logic [31:0] csr_request__data;
  logic        csr_response__acknowledge = 1'b0;
  logic        csr_response__read_data_valid = 1'b0;
  logic        csr_response__read_data_error = 1'b0;
  logic [31:0] csr_response__read_data = '0;

  picoriscv_csr_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                           (clk),
    .clk__enable                   (clk__enable),
    .reset_n                       (reset_n),
    .host_req_valid                (host_req_valid),
    .host_req_ready                (host_req_ready),
    .host_req_read_not_write       (host_req_read_not_write),
    .host_req_select               (host_req_select),
    .host_req_address              (host_req_address),
    .host_req_data                 (host_req_data),
    .host_rsp_valid                (host_rsp_valid),
    .host_rsp_error                (host_rsp_error),
    .host_rsp_timeout              (host_rsp_timeout),
    .host_rsp_data                 (host_rsp_data),
    .csr_request__valid            (csr_request__valid),
    .csr_request__read_not_write   (csr_request__read_not_write),
    .csr_request__select           (csr_request__select),
    .csr_request__address          (csr_request__address),
    .csr_request__data             (csr_request__data),
    .csr_response__acknowledge     (csr_response__acknowledge),
    .csr_response__read_data_valid (csr_response__read_data_valid),
    .csr_response__read_data_error (csr_response__read_data_error),
    .csr_response__read_data       (csr_response__read_data)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // Expected entry: {timeout, error, data[31:0], request_cycles[7:0], wait_cycles[7:0]}
  logic [49:0] exp_q[$];
  logic [32:0] exp_cmd_hdr = '0;
  logic [31:0] exp_cmd_data = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          accept_cnt = 0;
  int          acc_seen = 0;
  logic        busy = 1'b0;
  int          req_cnt = 0;
  int          wait_cnt = 0;
  int          rsp_count = 0;
  logic        last_to = 1'b0;
  logic        last_err = 1'b0;
  logic [31:0] last_data = '0;
  int          last_req = 0;
  int          last_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    logic [49:0] e;
    if (!reset_n) begin
      busy = 1'b0;
      req_cnt = 0;
      wait_cnt = 0;
      exp_q.delete();
      acc_seen = accept_cnt;
    end else begin
      if (accept_cnt != acc_seen) begin
        acc_seen = accept_cnt;
        busy = 1'b1;
      end
      chk("ready", 64'(host_req_ready), 64'(!busy));
      chk("err_and_timeout", 64'(host_rsp_error & host_rsp_timeout), 64'd0);
      if (!host_rsp_valid)
        chk("rsp_idle_zero", {30'd0, host_rsp_error, host_rsp_timeout, host_rsp_data}, 64'd0);
      if (!busy) chk("req_valid_idle", 64'(csr_request__valid), 64'd0);
      if (csr_request__valid) begin
        chk("req_cmd", 64'({csr_request__read_not_write, csr_request__select, csr_request__address}),
            64'(exp_cmd_hdr));
        chk("req_data", 64'(csr_request__data), 64'(exp_cmd_data));
        if (clk__enable) req_cnt++;
      end else if (busy && !host_rsp_valid && clk__enable) begin
        wait_cnt++;
      end
      if (host_rsp_valid && clk__enable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(host_rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_timeout", 64'(host_rsp_timeout), 64'(e[49]));
          chk("rsp_error", 64'(host_rsp_error), 64'(e[48]));
          chk("rsp_data", 64'(host_rsp_data), 64'(e[47:16]));
          chk("req_cycles", 64'(req_cnt), 64'(e[15:8]));
          chk("wait_cycles", 64'(wait_cnt), 64'(e[7:0]));
        end
        last_to   = host_rsp_timeout;
        last_err  = host_rsp_error;
        last_data = host_rsp_data;
        last_req  = req_cnt;
        last_wait = wait_cnt;
        rsp_count++;
        busy = 1'b0;
        req_cnt = 0;
        wait_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic pick_en(input bit rand_en);
    return rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // Inputs for the current cycle are applied just after a rising edge; returns 1 ns after the next one.
  task automatic drive_cycle(input logic en, input logic ack, input logic rdv, input logic err,
                             input logic [31:0] rd);
    clk__enable = en;
    csr_response__acknowledge = ack;
    csr_response__read_data_valid = rdv;
    csr_response__read_data_error = err;
    csr_response__read_data = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // ack_at: enabled request cycle (1-based) carrying ack, 0 = never.
  // rdv_after: enabled cycles after the ack cycle carrying read data (0 = same cycle, >TO = never).
  task automatic run_txn(input logic rnw, input logic [15:0] sel, input logic [15:0] addr,
                         input logic [31:0] wd, input int ack_at, input int rdv_after,
                         input logic [31:0] rd, input logic rerr, input bit rand_en,
                         input bit noise, input int abort_after);
    int req_n, wait_n, total, n, guard, cur;
    logic t_req, t_e, e_e, en, acc, ack, rdv, err;
    logic [31:0] d_e, rdd;
    t_req = (ack_at < 1) || (ack_at > TO);
    t_e = t_req;
    e_e = 1'b0;
    d_e = 32'h0;
    wait_n = 0;
    req_n = t_req ? TO : ack_at;
    if (!t_req && rnw) begin
      if (rdv_after <= TO) begin
        wait_n = rdv_after;
        d_e = rd;
        e_e = rerr;
      end else begin
        wait_n = TO;
        t_e = 1'b1;
      end
    end
    total = req_n + wait_n + 1;
    exp_cmd_hdr = {rnw, sel, addr};
    exp_cmd_data = wd;
    if (abort_after == 0) exp_q.push_back({t_e, e_e, d_e, 8'(req_n), 8'(wait_n)});

    host_req_valid = 1'b1;
    host_req_read_not_write = rnw;
    host_req_select = sel;
    host_req_address = addr;
    host_req_data = wd;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      en = pick_en(rand_en);
      acc = en && host_req_ready;
      drive_cycle(en, 1'b0, 1'b0, 1'b0, 32'h0);
      guard++;
    end
    chk("accept_bound", 64'(acc), 64'd1);
    host_req_valid = 1'b0;
    host_req_read_not_write = ~rnw;
    host_req_select = ~sel;
    host_req_address = ~addr;
    host_req_data = ~wd;
    if (acc) accept_cnt++;

    n = 0;
    guard = 0;
    while (acc && n < total && (abort_after == 0 || n < abort_after) && guard < 400) begin
      en = pick_en(rand_en);
      cur = n + 1;
      ack = 1'b0;
      rdv = 1'b0;
      err = 1'b0;
      rdd = 32'h0;
      if (!en) begin
        ack = 1'($urandom_range(0, 1));
        rdv = 1'($urandom_range(0, 1));
        err = 1'($urandom_range(0, 1));
        rdd = $urandom;
      end else begin
        if (!t_req && cur == ack_at) ack = 1'b1;
        if (rnw && !t_req && rdv_after <= TO && cur == ack_at + rdv_after) begin
          rdv = 1'b1;
          err = rerr;
          rdd = rd;
        end else if (noise && ((t_req && cur <= req_n) || (!t_req && cur < ack_at) || cur == total)) begin
          rdv = 1'b1;
          err = 1'($urandom_range(0, 1));
          rdd = $urandom;
        end
      end
      drive_cycle(en, ack, rdv, err, rdd);
      if (en) n++;
      guard++;
    end
    chk("txn_cycle_bound", 64'(guard < 400), 64'd1);
    clk__enable = 1'b1;
    csr_response__acknowledge = 1'b0;
    csr_response__read_data_valid = 1'b0;
    csr_response__read_data_error = 1'b0;
    csr_response__read_data = 32'h0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(host_req_ready), 64'd1);
    chk("reset_req_valid", 64'(csr_request__valid), 64'd0);
    chk("reset_rsp_valid", 64'(host_rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(host_rsp_data), 64'd0);
    @(posedge clk);
    #1;

    // Write, ack on third request cycle.
    cnt0 = rsp_count;
    run_txn(1'b0, 16'h0001, 16'h0010, 32'hDEADBEEF, 3, 0, 32'h0, 1'b0, 0, 0, 0);
    chk("w_rsp_count", 64'(rsp_count), 64'(cnt0 + 1));
    chk("w_data", 64'(last_data), 64'h0);
    chk("w_req_cycles", 64'(last_req), 64'd3);
    idle_cycles(2);

    // Read, ack cycle 2, data cycle 5.
    run_txn(1'b1, 16'h0002, 16'h0020, 32'h0, 2, 3, 32'h12345678, 1'b0, 0, 0, 0);
    chk("r_data", 64'(last_data), 64'h12345678);
    chk("r_wait_cycles", 64'(last_wait), 64'd3);
    idle_cycles(1);

    // Read, ack and data together.
    run_txn(1'b1, 16'h0003, 16'h0030, 32'h0, 1, 0, 32'hA5A5A5A5, 1'b0, 0, 0, 0);
    chk("r0_data", 64'(last_data), 64'hA5A5A5A5);
    chk("r0_wait_cycles", 64'(last_wait), 64'd0);

    // Read returning an error.
    run_txn(1'b1, 16'h0004, 16'h0040, 32'h0, 2, 1, 32'hCAFEF00D, 1'b1, 0, 0, 0);
    chk("rerr_error", 64'(last_err), 64'd1);
    chk("rerr_data", 64'(last_data), 64'hCAFEF00D);

    // Write with no ack: times out after TO request cycles.
    run_txn(1'b0, 16'h0005, 16'h0050, 32'h11112222, 0, 0, 32'h0, 1'b0, 0, 0, 0);
    chk("to_flag", 64'(last_to), 64'd1);
    chk("to_req_cycles", 64'(last_req), 64'd8);
    chk("to_data", 64'(last_data), 64'h0);

    // Read acked but data never arrives.
    run_txn(1'b1, 16'h0006, 16'h0060, 32'h0, 1, 99, 32'h0, 1'b0, 0, 0, 0);
    chk("rto_flag", 64'(last_to), 64'd1);
    chk("rto_wait_cycles", 64'(last_wait), 64'd8);

    // Ack on the final allowed request cycle beats the timeout.
    run_txn(1'b0, 16'h0007, 16'h0070, 32'h33334444, 8, 0, 32'h0, 1'b0, 0, 0, 0);
    chk("ackwin_flag", 64'(last_to), 64'd0);
    chk("ackwin_req_cycles", 64'(last_req), 64'd8);

    // Data on the final allowed wait cycle, random clock enable.
    run_txn(1'b1, 16'h0008, 16'h0080, 32'h0, 4, 8, 32'h0BADC0DE, 1'b0, 1, 0, 0);
    chk("lastwait_data", 64'(last_data), 64'h0BADC0DE);
    chk("lastwait_flag", 64'(last_to), 64'd0);

    // Stray read data outside the capture window, random enable.
    run_txn(1'b1, 16'h0009, 16'h0090, 32'h0, 3, 2, 32'h55AA55AA, 1'b0, 1, 1, 0);
    run_txn(1'b0, 16'h000A, 16'h00A0, 32'h77778888, 2, 0, 32'h0, 1'b0, 1, 1, 0);
    run_txn(1'b1, 16'h000B, 16'h00B0, 32'h0, 0, 0, 32'h0, 1'b0, 1, 1, 0);

    // Reset while in READ_WAIT: no completion must appear.
    cnt0 = rsp_count;
    run_txn(1'b1, 16'h000C, 16'h00C0, 32'h0, 1, 99, 32'h0, 1'b0, 1, 0, 3);
    reset_n = 1'b0;
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) drive_cycle(pick_en(1), 1'b0, 1'b0, 1'b0, 32'h0);
    reset_n = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_ready", 64'(host_req_ready), 64'd1);
    chk("rst_req_valid", 64'(csr_request__valid), 64'd0);
    chk("rst_rsp_valid", 64'(host_rsp_valid), 64'd0);
    chk("rst_no_rsp", 64'(rsp_count), 64'(cnt0));
    @(posedge clk);
    #1;

    // Normal operation after the abandon.
    run_txn(1'b1, 16'h000D, 16'h00D0, 32'h0, 2, 2, 32'h87654321, 1'b0, 0, 0, 0);
    chk("post_rst_data", 64'(last_data), 64'h87654321);
    idle_cycles(3);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
